// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI transaction arbiter.
// Register map of the spi block plus payload field widths.
package spi_pkg;

  localparam int CMD_W  = 8;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  localparam logic [2:0] ENABLE   = 3'd0;
  localparam logic [2:0] COMMAND  = 3'd1;
  localparam logic [2:0] ADDRESS  = 3'd2;
  localparam logic [2:0] DATA_IN  = 3'd3;
  localparam logic [2:0] DATA_OUT = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_EN,
    S_WAIT,
    S_RD,
    S_WR_DIS,
    S_RESP
  } spi_arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational winner select over the request vector.
// SPI_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module spi_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic                     o_valid,
  output logic [$clog2(N_REQ)-1:0] o_win
);

  localparam int IW = $clog2(N_REQ);

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    o_valid = |i_req;
    o_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) o_win = IW'(k);
    end
  end
`else
  logic [IW:0] w_j;

  // Scan from farthest to nearest so the nearest set bit after i_last wins.
  always_comb begin
    o_valid = |i_req;
    o_win   = '0;
    w_j     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_j = {1'b0, i_last} + (IW+1)'(k);
      if (w_j >= (IW+1)'(N_REQ)) w_j = w_j - (IW+1)'(N_REQ);
      if (i_req[w_j[IW-1:0]]) o_win = w_j[IW-1:0];
    end
  end
`endif

endmodule

// File: rtl/spi_txn_arbiter.sv
// Sequences full flash-style SPI transactions for N_REQ requesters.
// Optional SPI_ARB_FIXED_PRIO_EN: fixed priority, no round-robin pointer.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int XFER_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*CMD_W-1:0]  req_cmd,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    rsp_valid,
  output logic [2:0]              rsp_id,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [2:0]              spi_addr,
  output logic                    spi_we,
  output logic [DATA_W-1:0]       spi_write_data,
  output logic                    spi_re,
  input  logic [DATA_W-1:0]       spi_read_data
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(XFER_CYCLES + 1);

  spi_arb_state_t r_state;
  spi_arb_state_t w_next;

  logic [CMD_W-1:0]  r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [IW-1:0]     r_id;
  logic [CW-1:0]     r_cnt;
  logic [N_REQ-1:0]  r_gnt;
  logic [DATA_W-1:0] r_rdata;

  logic              w_valid;
  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_last;
  logic              w_take;
  logic [CMD_W-1:0]  w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

`ifdef SPI_ARB_FIXED_PRIO_EN
  assign w_last = '0;
`else
  logic [IW-1:0] r_last;
  assign w_last = r_last;
`endif

  spi_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (req),
    .i_last  (w_last),
    .o_valid (w_valid),
    .o_win   (w_win)
  );

  assign w_take = (r_state == S_IDLE) && w_valid;

  always_comb begin
    w_cmd   = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IW'(i)) begin
        w_cmd   = req_cmd[i*CMD_W +: CMD_W];
        w_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_valid) w_next = S_WR_CMD;
      S_WR_CMD:  w_next = S_WR_ADDR;
      S_WR_ADDR: w_next = S_WR_DATA;
      S_WR_DATA: w_next = S_WR_EN;
      S_WR_EN:   w_next = S_WAIT;
      S_WAIT:    if (r_cnt == '0) w_next = S_RD;
      S_RD:      w_next = S_WR_DIS;
      S_WR_DIS:  w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_rdata <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      r_last  <= IW'(N_REQ - 1);
`endif
    end else begin
      r_gnt <= '0;
      if (w_take) begin
        r_gnt   <= N_REQ'(1) << w_win;
        r_cmd   <= w_cmd;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_id    <= w_win;
`ifndef SPI_ARB_FIXED_PRIO_EN
        r_last  <= w_win;
`endif
      end
      // Loaded one short so WAIT spans exactly XFER_CYCLES cycles.
      if (r_state == S_WR_EN)
        r_cnt <= CW'(XFER_CYCLES - 1);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
      if (r_state == S_RD) r_rdata <= spi_read_data;
    end
  end

  always_comb begin
    spi_addr       = ENABLE;
    spi_we         = 1'b0;
    spi_write_data = '0;
    spi_re         = 1'b0;
    rsp_valid      = 1'b0;
    rsp_id         = 3'd0;
    unique case (r_state)
      S_WR_CMD: begin
        spi_addr       = COMMAND;
        spi_we         = 1'b1;
        spi_write_data = {{(DATA_W-CMD_W){1'b0}}, r_cmd};
      end
      S_WR_ADDR: begin
        spi_addr       = ADDRESS;
        spi_we         = 1'b1;
        spi_write_data = {{(DATA_W-ADDR_W){1'b0}}, r_addr};
      end
      S_WR_DATA: begin
        spi_addr       = DATA_IN;
        spi_we         = 1'b1;
        spi_write_data = r_wdata;
      end
      S_WR_EN: begin
        spi_we         = 1'b1;
        spi_write_data = DATA_W'(1);
      end
      S_RD: begin
        spi_addr = DATA_OUT;
        spi_re   = 1'b1;
      end
      S_WR_DIS: spi_we = 1'b1;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = 3'(r_id);
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign gnt       = r_gnt;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with hand-computed expectations.
// Covers reset, arbitration order, bus sequence, latency, payload and abort.
module tb_spi_txn_arbiter;
  import spi_pkg::*;

  localparam int N  = 4;
  localparam int XC = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*8-1:0]  req_cmd;
  logic [N*24-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          rsp_valid;
  logic [2:0]    rsp_id;
  logic [31:0]   rsp_rdata;
  logic [2:0]    spi_addr;
  logic          spi_we;
  logic [31:0]   spi_write_data;
  logic          spi_re;
  logic [31:0]   spi_read_data;

  spi_txn_arbiter #(
    .N_REQ       (N),
    .XFER_CYCLES (XC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_cmd        (req_cmd),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .busy           (busy),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_rdata      (rsp_rdata),
    .spi_addr       (spi_addr),
    .spi_we         (spi_we),
    .spi_write_data (spi_write_data),
    .spi_re         (spi_re),
    .spi_read_data  (spi_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int n_rsp = 0;
  int bl_cyc[$];
  logic [36:0] bl_ent[$];

  always @(negedge clk) begin
    if (spi_we || spi_re) begin
      bl_cyc.push_back(cyc);
      bl_ent.push_back({spi_re, spi_we, spi_addr, spi_write_data});
    end
    if (rsp_valid) n_rsp++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] ent(input logic re, input logic we,
                                      input logic [2:0] a,
                                      input logic [31:0] d);
    return {re, we, a, d};
  endfunction

  task automatic wait_gnt(input int t0, output int rel,
                          output logic [N-1:0] g);
    rel = -1;
    g   = '0;
    for (int k = 0; k < 400 && rel < 0; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        rel = cyc - t0;
        g   = gnt;
      end
    end
  endtask

  task automatic wait_rsp(input int t0, output int rel,
                          output logic [2:0] id, output logic [31:0] rd);
    rel = -1;
    id  = '0;
    rd  = '0;
    for (int k = 0; k < 400 && rel < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rel = cyc - t0;
        id  = rsp_id;
        rd  = rsp_rdata;
      end
    end
  endtask

  int            t0;
  int            rel;
  int            nr;
  int            ex;
  logic [N-1:0]  g;
  logic [2:0]    id;
  logic [31:0]   rd;
  logic [36:0]   exp_e[6];
  int            exp_c[6];
  int            exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst           = 1'b0;
    req           = '0;
    req_cmd       = '0;
    req_addr      = '0;
    req_wdata     = '0;
    spi_read_data = 32'h0;
    repeat (3) @(negedge clk);

    check("rst_gnt",   64'(gnt), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_rspv",  64'(rsp_valid), 64'd0);
    check("rst_rspid", 64'(rsp_id), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_bus",   64'({spi_addr, spi_we, spi_re, spi_write_data}), 64'd0);

    rst = 1'b1;
    @(negedge clk);

    // Contention: all four request, re-asserted after each response.
    spi_read_data = 32'hCAFE_0000;
    for (int n = 0; n < 5; n++) begin
      t0  = cyc;
      req = '1;
      wait_gnt(t0, rel, g);
      req = '0;
`ifdef SPI_ARB_FIXED_PRIO_EN
      ex = 0;
`else
      ex = exp_rr[n];
`endif
      check($sformatf("cont_gnt%0d", n), 64'(g), 64'(1) << ex);
      wait_rsp(t0, rel, id, rd);
      check($sformatf("cont_id%0d", n), 64'(id), 64'(ex));
    end
    @(negedge clk);

    // Single request from requester 2.
    req_cmd   = 32'h1103_2233;
    req_addr  = {24'hEEEEEE, 24'h001234, 24'h777777, 24'h555555};
    req_wdata = {32'hDEAD_BEEF, 32'hA5A5_0001, 32'h1111_1111, 32'h2222_2222};
    spi_read_data = 32'h5A5A_1234;
    bl_cyc.delete();
    bl_ent.delete();
    t0  = cyc;
    req = 4'b0100;
    wait_gnt(t0, rel, g);
    req = '0;
    check("s_gnt_cyc", 64'(rel), 64'd1);
    check("s_gnt",     64'(g), 64'b0100);
    check("s_busy",    64'(busy), 64'd1);
    wait_rsp(t0, rel, id, rd);
    check("s_rsp_cyc", 64'(rel), 64'(XC + 7));
    check("s_rsp_id",  64'(id), 64'd2);
    check("s_rdata",   64'(rd), 64'h5A5A_1234);
    @(negedge clk);
    check("s_idle",    64'(busy), 64'd0);
    check("s_rspv_lo", 64'(rsp_valid), 64'd0);
    exp_e[0] = ent(1'b0, 1'b1, COMMAND,  32'h0000_0003);
    exp_e[1] = ent(1'b0, 1'b1, ADDRESS,  32'h0000_1234);
    exp_e[2] = ent(1'b0, 1'b1, DATA_IN,  32'hA5A5_0001);
    exp_e[3] = ent(1'b0, 1'b1, ENABLE,   32'h0000_0001);
    exp_e[4] = ent(1'b1, 1'b0, DATA_OUT, 32'h0000_0000);
    exp_e[5] = ent(1'b0, 1'b1, ENABLE,   32'h0000_0000);
    exp_c    = '{1, 2, 3, 4, XC + 5, XC + 6};
    check("s_bus_n", 64'(bl_ent.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < bl_ent.size()) begin
        check($sformatf("s_bus%0d", i), 64'(bl_ent[i]), 64'(exp_e[i]));
        check($sformatf("s_cyc%0d", i), 64'(bl_cyc[i] - t0), 64'(exp_c[i]));
      end
    end

    // Back-to-back: requester 1 holds req through the response.
    spi_read_data = 32'h0BAD_F00D;
    nr  = n_rsp;
    t0  = cyc;
    req = 4'b0010;
    wait_gnt(t0, rel, g);
    check("b_gnt1_cyc", 64'(rel), 64'd1);
    wait_rsp(t0, rel, id, rd);
    check("b_rsp1_cyc", 64'(rel), 64'(XC + 7));
    wait_gnt(t0, rel, g);
    req = '0;
    check("b_gnt2_cyc", 64'(rel), 64'(XC + 9));
    check("b_gnt2",     64'(g), 64'b0010);
    wait_rsp(t0, rel, id, rd);
    check("b_rsp2_id",  64'(id), 64'd1);
    @(negedge clk);
    check("b_rsp_cnt",  64'(n_rsp - nr), 64'd2);

    // Payload changes after the grant must not reach the bus.
    req_cmd[7:0]    = 8'h9F;
    req_addr[23:0]  = 24'hABCDEF;
    req_wdata[31:0] = 32'h0102_0304;
    bl_cyc.delete();
    bl_ent.delete();
    t0  = cyc;
    req = 4'b0001;
    wait_gnt(t0, rel, g);
    req = '0;
    req_addr[23:0]  = 24'h111111;
    req_wdata[31:0] = 32'hFFFF_FFFF;
    @(negedge clk);
    req_cmd[7:0] = 8'h05;
    wait_rsp(t0, rel, id, rd);
    check("p_bus_n", 64'(bl_ent.size()), 64'd6);
    if (bl_ent.size() >= 3) begin
      check("p_cmd",  64'(bl_ent[0]), 64'(ent(1'b0, 1'b1, COMMAND, 32'h9F)));
      check("p_addr", 64'(bl_ent[1]), 64'(ent(1'b0, 1'b1, ADDRESS, 32'hABCDEF)));
      check("p_data", 64'(bl_ent[2]), 64'(ent(1'b0, 1'b1, DATA_IN, 32'h0102_0304)));
    end
    @(negedge clk);

    // Reset in the middle of WAIT.
    spi_read_data = 32'h1357_9BDF;
    t0  = cyc;
    req = 4'b0001;
    wait_gnt(t0, rel, g);
    req = '0;
    while (cyc - t0 < 20) @(negedge clk);
    check("r_busy_pre", 64'(busy), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("r_busy",  64'(busy), 64'd0);
    check("r_gnt",   64'(gnt), 64'd0);
    check("r_rspv",  64'(rsp_valid), 64'd0);
    check("r_rdata", 64'(rsp_rdata), 64'd0);
    check("r_bus",   64'({spi_addr, spi_we, spi_re, spi_write_data}), 64'd0);
    nr  = n_rsp;
    req = 4'b1000;
    @(negedge clk);
    rst = 1'b1;
    t0  = cyc;
    wait_gnt(t0, rel, g);
    req = '0;
    check("r_gnt_cyc", 64'(rel), 64'd1);
    check("r_gnt3",    64'(g), 64'b1000);
    wait_rsp(t0, rel, id, rd);
    check("r_rsp_id",  64'(id), 64'd3);
    check("r_rdata2",  64'(rd), 64'h1357_9BDF);
    @(negedge clk);
    check("r_rsp_cnt", 64'(n_rsp - nr), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
